// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the sequential ALU.
//   - ALUop encodings (OP_ADD .. OP_SEQ); 1011..1111 are reserved.
//   - FSM state encoding for alu_seq.
//   - Bit positions of the packed flag vector.
package alu_pkg;

    // ALUop[3] selects the comparison group, ALUop[2] the logic group.
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MULU = 4'b0010;
    localparam logic [3:0] OP_DIVU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_SEQ  = 4'b1010;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } alu_state_e;

    // Flag vector layout: {ovf, carry, neg, zero}.
    localparam int unsigned FlagZero  = 0;
    localparam int unsigned FlagNeg   = 1;
    localparam int unsigned FlagCarry = 2;
    localparam int unsigned FlagOvf   = 3;
    localparam int unsigned NumFlags  = 4;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result bus of the sequential ALU.
//   Input side : in_valid, in_ready, a, b, ALUop.
//   Output side: out_valid, out_ready, result, hi, flag_zero/neg/carry/ovf, busy.
//   Modports   : master (producer/consumer around the ALU), slave (the ALU).
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0]  ALUop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             flag_zero;
    logic             flag_neg;
    logic             flag_carry;
    logic             flag_ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, ALUop, out_ready,
        input  in_ready, out_valid, result, hi, flag_zero, flag_neg, flag_carry, flag_ovf,
               busy
    );

    modport slave (
        input  in_valid, a, b, ALUop, out_ready,
        output in_ready, out_valid, result, hi, flag_zero, flag_neg, flag_carry, flag_ovf,
               busy
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative unsigned multiply (shift-add) and divide (restoring),
// one bit per cycle, WIDTH iterations per operation.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   start_i      : load operands and begin an operation
//   div_i        : 1 = divide, 0 = multiply (sampled with start_i)
//   a_i, b_i     : multiplier/dividend, multiplicand/divisor
//   done_o       : the final iteration is being performed this cycle
//   lo_o, hi_o   : next-state of the lo/hi registers; on done_o they carry the
//                  final {product high, low} or {remainder, quotient}
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);
    import alu_pkg::*;

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    logic             running_q, running_d;
    logic             div_q, div_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;

    // Multiply step: hi is the accumulator, lo shifts out multiplier bits and
    // shifts in product bits from the top.
    logic [WIDTH:0]   mul_add, mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    assign mul_add = {1'b0, hi_q} + {1'b0, opnd_q};
    assign mul_sum = lo_q[0] ? mul_add : {1'b0, hi_q};
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Divide step: hi is the partial remainder, lo shifts out dividend bits and
    // shifts in quotient bits from the bottom.
    logic [WIDTH:0]   div_shift, div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi, div_lo;
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_sub   = div_shift - {1'b0, opnd_q};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    // A successful subtract leaves a value below the divisor, so bit WIDTH is 0.
    assign div_hi    = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo    = {lo_q[WIDTH-2:0], div_ge};

    logic unused_div_sub_msb;
    assign unused_div_sub_msb = div_sub[WIDTH];

    always_comb begin
        running_d = running_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        opnd_d    = opnd_q;
        if (start_i) begin
            running_d = 1'b1;
            div_d     = div_i;
            cnt_d     = '0;
            lo_d      = a_i;
            hi_d      = '0;
            opnd_d    = b_i;
        end else if (running_q) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
                running_d = 1'b0;
            end
            if (div_q) begin
                lo_d = div_lo;
                hi_d = div_hi;
            end else begin
                lo_d = mul_lo;
                hi_d = mul_hi;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            running_q <= 1'b0;
            div_q     <= 1'b0;
            cnt_q     <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            opnd_q    <= '0;
        end else begin
            running_q <= running_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            opnd_q    <= opnd_d;
        end
    end

    assign done_o = running_q && (cnt_q == LastCnt);
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with registered results and valid/ready on both sides.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high; aborts any operation in flight
//   bus_io : alu_seq_if.slave -- operands/ALUop in, result/hi/flags out, busy
// Single-cycle ops and divide-by-zero complete in 1 cycle; MULU/DIVU take WIDTH+1.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 4
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus_io
);
    import alu_pkg::*;

    alu_state_e state_q, state_d;

    logic [WIDTH-1:0]    result_q, result_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [NumFlags-1:0] flags_q, flags_d;

    logic [WIDTH-1:0] a, b;
    logic [OP_W-1:0]  op;
    logic             in_ready;
    logic             accept;

    assign a  = bus_io.a;
    assign b  = bus_io.b;
    assign op = bus_io.ALUop;

    assign in_ready = (state_q == StIdle) || ((state_q == StDone) && bus_io.out_ready);
    assign accept   = bus_io.in_valid && in_ready;

    // Single-cycle datapath, also covering divide-by-zero.
    logic [WIDTH:0]      sum, diff;
    logic [WIDTH-1:0]    sc_result, sc_hi;
    logic [NumFlags-1:0] sc_flags;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        sc_result = '0;
        sc_hi     = '0;
        sc_flags  = '0;
        unique case (op)
            OP_ADD: begin
                sc_result           = sum[WIDTH-1:0];
                sc_flags[FlagCarry] = sum[WIDTH];
                sc_flags[FlagOvf]   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result           = diff[WIDTH-1:0];
                sc_flags[FlagCarry] = diff[WIDTH];
                sc_flags[FlagOvf]   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_DIVU: begin
                // Only reached here with b == 0.
                sc_result         = '1;
                sc_hi             = a;
                sc_flags[FlagOvf] = 1'b1;
            end
            OP_AND: sc_result = a & b;
            OP_OR:  sc_result = a | b;
            OP_XOR: sc_result = a ^ b;
            OP_NOR: sc_result = ~(a | b);
            OP_SLT: begin
                sc_result          = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                sc_flags[FlagZero] = (a == b);
            end
            OP_SLTU: begin
                sc_result          = {{(WIDTH-1){1'b0}}, (a < b)};
                sc_flags[FlagZero] = (a == b);
            end
            OP_SEQ: begin
                sc_result          = {{(WIDTH-1){1'b0}}, (a == b)};
                sc_flags[FlagZero] = (a == b);
            end
            default: ;  // MULU never completes here; reserved ops give all zeros
        endcase
        if (!op[3]) begin
            sc_flags[FlagZero] = (sc_result == '0);
        end
        sc_flags[FlagNeg] = sc_result[WIDTH-1];
    end

    // Iterative multiply/divide.
    logic             iter_start, iter_div, iter_done;
    logic [WIDTH-1:0] iter_lo, iter_hi;

    assign iter_div = (op == OP_DIVU);

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk_i  (clk),
        .rst_i  (reset),
        .start_i(iter_start),
        .div_i  (iter_div),
        .a_i    (a),
        .b_i    (b),
        .done_o (iter_done),
        .lo_o   (iter_lo),
        .hi_o   (iter_hi)
    );

    logic [NumFlags-1:0] iter_flags;
    always_comb begin
        iter_flags            = '0;
        iter_flags[FlagZero]  = (iter_lo == '0);
        iter_flags[FlagNeg]   = iter_lo[WIDTH-1];
        iter_flags[FlagCarry] = (state_q == StMul) && (iter_hi != '0);
    end

    // Decide where an accepted op goes; shared by IDLE and DONE.
    alu_state_e accept_state;
    logic       accept_iter;
    always_comb begin
        accept_iter  = 1'b0;
        accept_state = StDone;
        if (op == OP_MULU) begin
            accept_iter  = 1'b1;
            accept_state = StMul;
        end else if ((op == OP_DIVU) && (b != '0)) begin
            accept_iter  = 1'b1;
            accept_state = StDiv;
        end
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        hi_d       = hi_q;
        flags_d    = flags_q;
        iter_start = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if ((state_q == StDone) && bus_io.out_ready) begin
                    state_d = StIdle;
                end
                if (accept) begin
                    state_d    = accept_state;
                    iter_start = accept_iter;
                    if (!accept_iter) begin
                        result_d = sc_result;
                        hi_d     = sc_hi;
                        flags_d  = sc_flags;
                    end
                end
            end
            StMul, StDiv: begin
                if (iter_done) begin
                    state_d  = StDone;
                    result_d = iter_lo;
                    hi_d     = iter_hi;
                    flags_d  = iter_flags;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            hi_q     <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            flags_q  <= flags_d;
        end
    end

    assign bus_io.in_ready   = in_ready;
    assign bus_io.out_valid  = (state_q == StDone);
    assign bus_io.busy       = (state_q == StMul) || (state_q == StDiv);
    assign bus_io.result     = result_q;
    assign bus_io.hi         = hi_q;
    assign bus_io.flag_zero  = flags_q[FlagZero];
    assign bus_io.flag_neg   = flags_q[FlagNeg];
    assign bus_io.flag_carry = flags_q[FlagCarry];
    assign bus_io.flag_ovf   = flags_q[FlagOvf];

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (WIDTH=32) with a scoreboard.
// Expected responses are queued at issue time; a negedge monitor pops and
// compares on every output handshake.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        string          name;
        logic [W-1:0]   res;
        logic [W-1:0]   hi;
        logic [3:0]     flags;  // {ovf, carry, neg, zero}
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   pop_cyc[$];
    exp_t mon_e;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got result 0x%0h with nothing expected",
                         bus.result);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_out"},
                      96'({bus.result, bus.hi, bus.flag_ovf, bus.flag_carry, bus.flag_neg,
                           bus.flag_zero}),
                      96'({mon_e.res, mon_e.hi, mon_e.flags}));
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Present an op, wait (bounded) for in_ready, queue its expectation and
    // return #1 after the accept edge. keep leaves in_valid high for streaming.
    task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] er,
                         input logic [W-1:0] eh, input logic [3:0] ef, input bit keep);
        int waited = 0;
        bus.ALUop    = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check({name, "_in_ready"}, 96'(bus.in_ready), 96'(1));
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            return;
        end
        exp_q.push_back('{name, er, eh, ef});
        @(posedge clk);
        #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge: measure latency to out_valid and, for
    // iterative ops, confirm busy=1 / in_ready=0 throughout.
    task automatic wait_out(input string name, input int exp_lat, input bit iter);
        int lat = 1;
        int bad = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 96'(lat), 96'(exp_lat));
        if (iter) check({name, "_busy_stall"}, 96'(bad), 96'(0));
    endtask

    task automatic run(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic [W-1:0] eh,
                       input logic [3:0] ef, input int lat, input bit iter);
        issue(name, op, a, b, er, eh, ef, 1'b0);
        wait_out(name, lat, iter);
    endtask

    initial begin
        int vcount;
        int waited;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ALUop     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state",
              96'({bus.out_valid, bus.busy, bus.result, bus.hi, bus.flag_ovf, bus.flag_carry,
                   bus.flag_neg, bus.flag_zero}), 96'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Flags below are {ovf, carry, neg, zero}.
        run("add_ovf",  OP_ADD,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0, 4'b1010, 1, 1'b0);
        run("sub_zero", OP_SUB,  32'd5, 32'd5, 32'h0, 32'h0, 4'b0101, 1, 1'b0);
        run("slt",      OP_SLT,  32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 4'b0000, 1, 1'b0);
        run("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 4'b0000, 1, 1'b0);
        run("seq",      OP_SEQ,  32'd7, 32'd7, 32'h1, 32'h0, 4'b0001, 1, 1'b0);
        run("and",      OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 32'h0, 4'b0000,
            1, 1'b0);
        run("or_zero",  OP_OR,   32'h0, 32'h0, 32'h0, 32'h0, 4'b0001, 1, 1'b0);
        run("xor",      OP_XOR,  32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0, 4'b0010,
            1, 1'b0);
        run("nor",      OP_NOR,  32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 4'b0010, 1, 1'b0);
        run("add_cy",   OP_ADD,  32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 4'b0101, 1, 1'b0);
        run("sub_brw",  OP_SUB,  32'd3, 32'd5, 32'hFFFF_FFFE, 32'h0, 4'b0010, 1, 1'b0);
        run("sub_ovf",  OP_SUB,  32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 32'h0, 4'b1100, 1, 1'b0);
        run("reserved", 4'b1100, 32'd5, 32'd5, 32'h0, 32'h0, 4'b0000, 1, 1'b0);
        run("mulu",     OP_MULU, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'h1, 4'b0110, 33, 1'b1);
        run("mulu_hi",  OP_MULU, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1, 4'b0101, 33, 1'b1);
        run("divu",     OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000, 33, 1'b1);
        run("divu_small", OP_DIVU, 32'd5, 32'd9, 32'd0, 32'd5, 4'b0001, 33, 1'b1);
        run("divu_zero", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 4'b1010, 1, 1'b0);

        // Back-pressure: result must hold while out_ready is low.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        issue("hold", OP_ADD, 32'h10, 32'h20, 32'h30, 32'h0, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("hold_stable", 96'({bus.out_valid, bus.in_ready, bus.result}),
                  96'({1'b1, 1'b0, 32'h30}));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Streaming: four back-to-back ADDs, one result per cycle.
        pop_cyc.delete();
        for (int i = 1; i <= 4; i++) begin
            issue("stream", OP_ADD, W'(i), W'(i), W'(2 * i), 32'h0, 4'b0000, 1'b1);
        end
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stream_count", 96'(pop_cyc.size()), 96'(4));
        if (pop_cyc.size() == 4) check("stream_spacing", 96'(pop_cyc[3] - pop_cyc[0]), 96'(3));

        // Reset in the middle of a multiply.
        issue("mul_abort", OP_MULU, 32'd1234, 32'd5678, 32'd7006652, 32'h0, 4'b0000, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy_before", 96'(bus.busy), 96'(1));
        reset = 1'b1;
        #1;
        check("abort_outputs", 96'({bus.out_valid, bus.busy, bus.result, bus.hi}), 96'(0));
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) vcount++;
            @(posedge clk);
            #1;
        end
        check("abort_no_result", 96'(vcount), 96'(0));
        run("post_reset_add", OP_ADD, 32'd2, 32'd3, 32'd5, 32'h0, 4'b0000, 1, 1'b0);

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("scoreboard_drained", 96'(exp_q.size()), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Next-generation ALU for the microprocessor datapath, parametrised in WIDTH.
- Adds iterative unsigned multiply and divide, a full flag set, and registered outputs with valid/ready handshakes on both sides.
- Sits between the register-read stage and the writeback/branch logic.
- Keeps the existing op grouping: ALUop[3] selects comparison, ALUop[2] selects logic.

Parameters:
- WIDTH, 32, operand and result width in bits; must be at least 4.
- OP_W, 4, ALUop width; fixed at 4 for this encoding.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and ALUop are valid this cycle.
- in_ready  out  1  block can accept an op this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ALUop  in  4  operation code.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result this cycle.
- result  out  WIDTH  primary result: sum/difference, product low half, quotient, logic value, or comparison bit.
- hi  out  WIDTH  product high half or remainder; 0 for all other ops.
- flag_zero  out  1  zero flag.
- flag_neg  out  1  negative flag, result[WIDTH-1].
- flag_carry  out  1  carry flag.
- flag_ovf  out  1  signed overflow flag.
- busy  out  1  multiply or divide iteration in progress.

Behaviour:
- ALUop encoding:
  - 0000 ADD, 0001 SUB, 0010 MULU, 0011 DIVU.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR.
  - 1000 SLT (signed), 1001 SLTU, 1010 SEQ.
  - 1011 to 1111 reserved: result=0, hi=0, all flags 0, latency 1.
- Reset: while reset is high, state=IDLE and out_valid, result, hi, all flags and busy are 0. Inputs are ignored while reset is high.
- Reset mid-operation aborts immediately; no partial result is ever emitted.
- Acceptance: an op is accepted when in_valid && in_ready on a rising edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives one result per cycle for single-cycle ops.
- State machine:
  - IDLE to DONE: accepted single-cycle op, or DIVU with b==0.
  - IDLE to MUL: accepted MULU.
  - IDLE to DIV: accepted DIVU with b!=0.
  - MUL/DIV to DONE: after WIDTH iterations.
  - DONE to IDLE: out_ready with no new accept.
  - DONE to DONE: out_ready together with a new single-cycle accept.
  - DONE to MUL/DIV: out_ready together with a new MULU/DIVU accept.
- Latency, with out_valid rising on the edge after the accept edge counted as 1:
  - Single-cycle ops: 1.
  - MULU and DIVU: WIDTH+1.
  - DIVU by zero: 1.
- Handshake and output stability:
  - out_valid and busy are registered.
  - result, hi and flags are held stable while out_valid && !out_ready.
  - in_ready is 0 throughout MUL and DIV states.
- MULU: shift-add, one partial product per cycle, unsigned; {hi,result} = a*b.
- DIVU: restoring, one quotient bit per cycle; result = a/b, hi = a%b.
- DIVU by zero: result = all ones, hi = a, flag_ovf = 1.
- Width rules: ADD/SUB are computed WIDTH+1 wide; the carry-out is bit WIDTH.
- flag_carry:
  - ADD: carry-out.
  - SUB: carry-out of a+~b+1, i.e. 1 when a>=b unsigned.
  - MULU: hi!=0.
  - All other ops: 0.
- flag_ovf:
  - ADD/SUB: signed overflow.
  - DIVU: divide by zero.
  - All other ops: 0.
- flag_zero:
  - Ops 0000 to 0111: result==0, with hi ignored.
  - Comparison ops: (a==b).
- Comparison result is zero-extended to WIDTH.

Decomposition:
- Package alu_pkg holds:
  - ALUop localparams (OP_ADD through OP_SEQ).
  - The state encoding: IDLE, MUL, DIV, DONE.
  - A flag-vector index constant.
- One sub-module, alu_muldiv_iter:
  - Iterative multiply/divide datapath with accumulator, shift registers and an iteration counter of width clog2(WIDTH)+1.
  - Driven by start/op/done signals from the alu_seq FSM.

Test Plan (all with WIDTH=32):
- ADD a=0x7FFFFFFF b=1 -> result 0x80000000, neg=1, ovf=1, carry=0, zero=0; out_valid asserts 1 cycle after accept.
- SUB 5-5 -> result 0, zero=1, carry=1. SLT a=0xFFFFFFFF b=1 -> result 1. SLTU with the same operands -> result 0, zero=0.
- MULU a=0xFFFFFFFF b=2 -> result 0xFFFFFFFE, hi=1, carry=1. out_valid exactly 33 cycles after accept; in_ready=0 and busy=1 during the iterations.
- DIVU 100/7 -> result 14, hi 2 after 33 cycles. DIVU 9/0 -> result 0xFFFFFFFF, hi 9, ovf=1 after 1 cycle.
- Hold out_ready low 5 cycles with a result pending -> outputs stable and in_ready=0. Then stream 4 back-to-back ADDs with out_ready high -> 4 results on 4 consecutive cycles, in order.
- Assert reset at iteration 10 of a MULU -> out_valid and busy drop to 0 immediately and no result is emitted. After release, ADD 2+3 -> result 5.
